// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester (CPU, DMA/copper) arbiter for a single-port
// synchronous RAM with a one-cycle read latency.
//
// Each grant runs one fixed four-state access:
//   IDLE -> ISSUE -> WAIT -> DONE -> IDLE
// The requester's command is latched at grant. ram_cs is high for the ISSUE
// cycle only. Read data is captured in WAIT, and the grantee's ready pulses in
// DONE. A request first seen in IDLE (cycle 0) therefore completes with ready
// in cycle 3. When both requesters are high in IDLE, grants alternate
// round-robin.
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   cpu_req / dma_req             request valid, held until ready is seen
//   cpu_address / dma_address     word address (ADDR_WIDTH bits)
//   cpu_wstrb / dma_wstrb         byte write strobes, 0 = read
//   cpu_write_data/dma_write_data write data
//   cpu_ready / dma_ready         one-cycle completion pulse
//   cpu_read_data / dma_read_data registered read result per requester
//   ram_cs, ram_address, ram_wstrb, ram_write_data  registered RAM command
//   ram_read_data                 RAM output, valid the cycle after ram_cs
//   busy                          high whenever the FSM is not in IDLE
module ram_arbiter #(
    parameter int unsigned ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  cpu_req,
    input  logic [ADDR_WIDTH-1:0] cpu_address,
    input  logic [3:0]            cpu_wstrb,
    input  logic [31:0]           cpu_write_data,
    output logic                  cpu_ready,
    output logic [31:0]           cpu_read_data,

    input  logic                  dma_req,
    input  logic [ADDR_WIDTH-1:0] dma_address,
    input  logic [3:0]            dma_wstrb,
    input  logic [31:0]           dma_write_data,
    output logic                  dma_ready,
    output logic [31:0]           dma_read_data,

    output logic                  ram_cs,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [3:0]            ram_wstrb,
    output logic [31:0]           ram_write_data,
    input  logic [31:0]           ram_read_data,

    output logic                  busy
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    // Grant encoding used by last_grant_q: 0 = CPU, 1 = DMA.
    localparam logic GRANT_CPU = 1'b0;
    localparam logic GRANT_DMA = 1'b1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [STRB_W-1:0]     wstrb;
        logic [DATA_W-1:0]     data;
    } ram_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q;
    ram_cmd_t            cmd_q;
    logic                last_grant_q;
    logic                ram_cs_q;
    logic                busy_q;
    logic                cpu_ready_q;
    logic                dma_ready_q;
    logic [DATA_W-1:0]   cpu_rdata_q;
    logic [DATA_W-1:0]   dma_rdata_q;

    ram_cmd_t            cpu_cmd_c;
    ram_cmd_t            dma_cmd_c;
    logic                grant_dma_c;
    ram_cmd_t            grant_cmd_c;

    // Requester commands packed for a single-mux latch at grant.
    always_comb begin
        cpu_cmd_c       = '0;
        dma_cmd_c       = '0;
        cpu_cmd_c.addr  = cpu_address;
        cpu_cmd_c.wstrb = cpu_wstrb;
        cpu_cmd_c.data  = cpu_write_data;
        dma_cmd_c.addr  = dma_address;
        dma_cmd_c.wstrb = dma_wstrb;
        dma_cmd_c.data  = dma_write_data;
    end

    // Round-robin pick: a lone requester always wins; on a tie the requester
    // that did not win last time gets the grant.
    always_comb begin
        grant_dma_c = dma_req && (!cpu_req || (last_grant_q == GRANT_CPU));
        grant_cmd_c = grant_dma_c ? dma_cmd_c : cpu_cmd_c;
    end

    // Access sequencer; every output is a register updated here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            last_grant_q <= GRANT_DMA;
            ram_cs_q     <= 1'b0;
            busy_q       <= 1'b0;
            cpu_ready_q  <= 1'b0;
            dma_ready_q  <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
        end else begin
            cpu_ready_q <= 1'b0;
            dma_ready_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (cpu_req || dma_req) begin
                        last_grant_q <= grant_dma_c;
                        cmd_q        <= grant_cmd_c;
                        ram_cs_q     <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= ISSUE;
                    end
                end

                ISSUE: begin
                    ram_cs_q <= 1'b0;
                    state_q  <= WAIT;
                end

                // RAM data for the ISSUE-cycle read is valid now; writes leave
                // both read registers untouched.
                WAIT: begin
                    if (cmd_q.wstrb == STRB_W'(0)) begin
                        if (last_grant_q == GRANT_DMA) begin
                            dma_rdata_q <= ram_read_data;
                        end else begin
                            cpu_rdata_q <= ram_read_data;
                        end
                    end
                    cpu_ready_q <= (last_grant_q == GRANT_CPU);
                    dma_ready_q <= (last_grant_q == GRANT_DMA);
                    state_q     <= DONE;
                end

                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    ram_cs_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign cpu_ready      = cpu_ready_q;
    assign dma_ready      = dma_ready_q;
    assign cpu_read_data  = cpu_rdata_q;
    assign dma_read_data  = dma_rdata_q;
    assign ram_cs         = ram_cs_q;
    assign ram_address    = cmd_q.addr;
    assign ram_wstrb      = cmd_q.wstrb;
    assign ram_write_data = cmd_q.data;
    assign busy           = busy_q;

    // Structural invariants of the sequencer.
    a_ready_onehot: assert property (@(posedge clk) disable iff (!reset_n)
        !(cpu_ready_q && dma_ready_q));
    a_cs_in_issue: assert property (@(posedge clk) disable iff (!reset_n)
        ram_cs_q == (state_q == ISSUE));
    a_busy_state: assert property (@(posedge clk) disable iff (!reset_n)
        busy_q == (state_q != IDLE));

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: table of single transactions plus
// hand-written sequences for tie alternation, mid-transaction input changes
// and reset during an access.
module tb_ram_arbiter;

    localparam int unsigned AW = 14;

    logic          clk;
    logic          reset_n;
    logic          cpu_req;
    logic [AW-1:0] cpu_address;
    logic [3:0]    cpu_wstrb;
    logic [31:0]   cpu_write_data;
    logic          cpu_ready;
    logic [31:0]   cpu_read_data;
    logic          dma_req;
    logic [AW-1:0] dma_address;
    logic [3:0]    dma_wstrb;
    logic [31:0]   dma_write_data;
    logic          dma_ready;
    logic [31:0]   dma_read_data;
    logic          ram_cs;
    logic [AW-1:0] ram_address;
    logic [3:0]    ram_wstrb;
    logic [31:0]   ram_write_data;
    logic [31:0]   ram_read_data;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    ram_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cpu_req        (cpu_req),
        .cpu_address    (cpu_address),
        .cpu_wstrb      (cpu_wstrb),
        .cpu_write_data (cpu_write_data),
        .cpu_ready      (cpu_ready),
        .cpu_read_data  (cpu_read_data),
        .dma_req        (dma_req),
        .dma_address    (dma_address),
        .dma_wstrb      (dma_wstrb),
        .dma_write_data (dma_write_data),
        .dma_ready      (dma_ready),
        .dma_read_data  (dma_read_data),
        .ram_cs         (ram_cs),
        .ram_address    (ram_address),
        .ram_wstrb      (ram_wstrb),
        .ram_write_data (ram_write_data),
        .ram_read_data  (ram_read_data),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-only RAM model: data is valid only in the cycle after ram_cs.
    logic [31:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        ram_read_data <= ram_cs ? mem[ram_address] : 32'hBAD0BAD0;
    end

    typedef struct {
        logic          cpu_req;
        logic [AW-1:0] cpu_addr;
        logic [3:0]    cpu_strb;
        logic [31:0]   cpu_wd;
        logic          dma_req;
        logic [AW-1:0] dma_addr;
        logic [3:0]    dma_strb;
        logic [31:0]   dma_wd;
        logic          exp_dma;
        logic [AW-1:0] exp_addr;
        logic [3:0]    exp_strb;
        logic [31:0]   exp_wd;
        logic [31:0]   exp_cpu_rd;
        logic [31:0]   exp_dma_rd;
    } vec_t;

    vec_t vecs [0:8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " cpu_ready"}, 32'(cpu_ready), 32'h0);
        chk({tag, " dma_ready"}, 32'(dma_ready), 32'h0);
        chk({tag, " ram_cs"}, 32'(ram_cs), 32'h0);
        chk({tag, " busy"}, 32'(busy), 32'h0);
        chk({tag, " ram_address"}, 32'(ram_address), 32'h0);
        chk({tag, " ram_wstrb"}, 32'(ram_wstrb), 32'h0);
        chk({tag, " ram_write_data"}, ram_write_data, 32'h0);
        chk({tag, " cpu_read_data"}, cpu_read_data, 32'h0);
        chk({tag, " dma_read_data"}, dma_read_data, 32'h0);
    endtask

    // One transaction starting in IDLE; leaves the DUT in IDLE with requests low.
    task automatic run_vec(input vec_t v, input int idx);
        string t;
        t = $sformatf("v%0d", idx);
        cpu_req = v.cpu_req; cpu_address = v.cpu_addr;
        cpu_wstrb = v.cpu_strb; cpu_write_data = v.cpu_wd;
        dma_req = v.dma_req; dma_address = v.dma_addr;
        dma_wstrb = v.dma_strb; dma_write_data = v.dma_wd;
        chk({t, " c0 busy"}, 32'(busy), 32'h0);
        chk({t, " c0 ram_cs"}, 32'(ram_cs), 32'h0);
        if (!v.cpu_req && !v.dma_req) begin
            for (int c = 1; c <= 4; c++) begin
                tick();
                chk($sformatf("%s idle c%0d busy", t, c), 32'(busy), 32'h0);
                chk($sformatf("%s idle c%0d ram_cs", t, c), 32'(ram_cs), 32'h0);
                chk($sformatf("%s idle c%0d readies", t, c), 32'({cpu_ready, dma_ready}), 32'h0);
            end
        end else begin
            tick();
            chk({t, " c1 ram_cs"}, 32'(ram_cs), 32'h1);
            chk({t, " c1 ram_address"}, 32'(ram_address), 32'(v.exp_addr));
            chk({t, " c1 ram_wstrb"}, 32'(ram_wstrb), 32'(v.exp_strb));
            chk({t, " c1 ram_write_data"}, ram_write_data, v.exp_wd);
            chk({t, " c1 busy"}, 32'(busy), 32'h1);
            tick();
            chk({t, " c2 ram_cs"}, 32'(ram_cs), 32'h0);
            chk({t, " c2 readies"}, 32'({cpu_ready, dma_ready}), 32'h0);
            chk({t, " c2 busy"}, 32'(busy), 32'h1);
            tick();
            chk({t, " c3 cpu_ready"}, 32'(cpu_ready), 32'(!v.exp_dma));
            chk({t, " c3 dma_ready"}, 32'(dma_ready), 32'(v.exp_dma));
            chk({t, " c3 ram_address hold"}, 32'(ram_address), 32'(v.exp_addr));
            chk({t, " c3 busy"}, 32'(busy), 32'h1);
            tick();
            cpu_req = 1'b0;
            dma_req = 1'b0;
            chk({t, " c4 busy"}, 32'(busy), 32'h0);
            chk({t, " c4 readies"}, 32'({cpu_ready, dma_ready}), 32'h0);
        end
        chk({t, " cpu_read_data"}, cpu_read_data, v.exp_cpu_rd);
        chk({t, " dma_read_data"}, dma_read_data, v.exp_dma_rd);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hF0000000 | 32'(i);
        mem[14'h0010] = 32'hDEADBEEF;
        mem[14'h0020] = 32'hA5A5A5A5;
        mem[14'h0001] = 32'h0BADF00D;
        mem[14'h3FFF] = 32'h11112222;
        mem[14'h0000] = 32'hCAFEF00D;
        mem[14'h2000] = 32'h89ABCDEF;
        mem[14'h0040] = 32'h13579BDF;
        mem[14'h0AAA] = 32'h0AAA0AAA;
        mem[14'h0555] = 32'h05550555;

        //          cpu: req addr     strb  wdata          dma: req addr     strb  wdata          exp: dma addr     strb  wdata          cpu_rd         dma_rd
        vecs[0] = '{1'b1, 14'h0010, 4'h0, 32'h11111111, 1'b0, 14'h0000, 4'h0, 32'h00000000, 1'b0, 14'h0010, 4'h0, 32'h11111111, 32'hDEADBEEF, 32'h00000000};
        vecs[1] = '{1'b0, 14'h0000, 4'h0, 32'h00000000, 1'b1, 14'h0100, 4'h3, 32'h12345678, 1'b1, 14'h0100, 4'h3, 32'h12345678, 32'hDEADBEEF, 32'h00000000};
        vecs[2] = '{1'b1, 14'h0020, 4'h0, 32'h22222222, 1'b1, 14'h0200, 4'h0, 32'h33333333, 1'b0, 14'h0020, 4'h0, 32'h22222222, 32'hA5A5A5A5, 32'h00000000};
        vecs[3] = '{1'b1, 14'h3FFF, 4'hF, 32'hFFFFFFFF, 1'b1, 14'h0001, 4'h0, 32'h44444444, 1'b1, 14'h0001, 4'h0, 32'h44444444, 32'hA5A5A5A5, 32'h0BADF00D};
        vecs[4] = '{1'b0, 14'h0000, 4'h0, 32'h00000000, 1'b1, 14'h3FFF, 4'h0, 32'h55555555, 1'b1, 14'h3FFF, 4'h0, 32'h55555555, 32'hA5A5A5A5, 32'h11112222};
        vecs[5] = '{1'b1, 14'h0000, 4'h0, 32'h66666666, 1'b1, 14'h0300, 4'hF, 32'h77777777, 1'b0, 14'h0000, 4'h0, 32'h66666666, 32'hCAFEF00D, 32'h11112222};
        vecs[6] = '{1'b1, 14'h1234, 4'h1, 32'h000000AA, 1'b0, 14'h0000, 4'h0, 32'h00000000, 1'b0, 14'h1234, 4'h1, 32'h000000AA, 32'hCAFEF00D, 32'h11112222};
        vecs[7] = '{1'b0, 14'h0000, 4'h0, 32'h00000000, 1'b0, 14'h0000, 4'h0, 32'h00000000, 1'b0, 14'h0000, 4'h0, 32'h00000000, 32'hCAFEF00D, 32'h11112222};
        vecs[8] = '{1'b1, 14'h0010, 4'h0, 32'h00000000, 1'b1, 14'h2000, 4'h0, 32'h88888888, 1'b1, 14'h2000, 4'h0, 32'h88888888, 32'hCAFEF00D, 32'h89ABCDEF};

        reset_n = 1'b0;
        cpu_req = 1'b0; cpu_address = '0; cpu_wstrb = '0; cpu_write_data = '0;
        dma_req = 1'b0; dma_address = '0; dma_wstrb = '0; dma_write_data = '0;
        tick();
        tick();
        chk_all_zero("reset");
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Command inputs change and request drops right after grant.
        cpu_req = 1'b1; cpu_address = 14'h0010; cpu_wstrb = 4'h0; cpu_write_data = 32'h0;
        tick();
        chk("hold c1 ram_address", 32'(ram_address), 32'h0010);
        cpu_req = 1'b0; cpu_address = 14'h0020; cpu_wstrb = 4'hF; cpu_write_data = 32'h99999999;
        tick();
        chk("hold c2 ram_address", 32'(ram_address), 32'h0010);
        chk("hold c2 ram_wstrb", 32'(ram_wstrb), 32'h0);
        tick();
        chk("hold c3 ram_address", 32'(ram_address), 32'h0010);
        chk("hold c3 cpu_ready", 32'(cpu_ready), 32'h1);
        chk("hold c3 cpu_read_data", cpu_read_data, 32'hDEADBEEF);
        tick();
        chk("hold c4 busy", 32'(busy), 32'h0);
        tick();
        chk("hold c5 ram_cs", 32'(ram_cs), 32'h0);

        // Reset during WAIT of a CPU read, request kept high throughout.
        cpu_req = 1'b1; cpu_address = 14'h0040; cpu_wstrb = 4'h0; cpu_write_data = 32'h0;
        tick();
        chk("rst c1 ram_cs", 32'(ram_cs), 32'h1);
        tick();
        reset_n = 1'b0;
        #1;
        chk_all_zero("rst low");
        tick();
        chk("rst low edge cpu_ready", 32'(cpu_ready), 32'h0);
        chk("rst low edge busy", 32'(busy), 32'h0);
        reset_n = 1'b1;
        tick();
        chk("rst re c1 ram_cs", 32'(ram_cs), 32'h1);
        chk("rst re c1 ram_address", 32'(ram_address), 32'h0040);
        tick();
        chk("rst re c2 cpu_ready", 32'(cpu_ready), 32'h0);
        tick();
        chk("rst re c3 cpu_ready", 32'(cpu_ready), 32'h1);
        chk("rst re c3 cpu_read_data", cpu_read_data, 32'h13579BDF);
        tick();
        cpu_req = 1'b0;
        chk("rst re c4 busy", 32'(busy), 32'h0);

        // Both requesters high from the first cycle after reset: six grants.
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        cpu_req = 1'b1; cpu_address = 14'h0AAA; cpu_wstrb = 4'h0;
        dma_req = 1'b1; dma_address = 14'h0555; dma_wstrb = 4'h0;
        for (int t = 0; t < 24; t++) begin
            chk($sformatf("rr t%0d ram_cs", t), 32'(ram_cs), 32'((t % 4) == 1));
            if ((t % 4) == 1) begin
                chk($sformatf("rr t%0d ram_address", t), 32'(ram_address),
                    ((t / 4) % 2 == 0) ? 32'h0AAA : 32'h0555);
            end
            chk($sformatf("rr t%0d cpu_ready", t), 32'(cpu_ready), 32'((t % 8) == 3));
            chk($sformatf("rr t%0d dma_ready", t), 32'(dma_ready), 32'((t % 8) == 7));
            chk($sformatf("rr t%0d busy", t), 32'(busy), 32'((t % 4) != 0));
            tick();
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        chk("rr end busy", 32'(busy), 32'h0);
        chk("rr cpu_read_data", cpu_read_data, 32'h0AAA0AAA);
        chk("rr dma_read_data", dma_read_data, 32'h05550555);
        tick();
        chk("rr after ram_cs", 32'(ram_cs), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
